// File: rtl/stack_sequencer_if.sv
// Command handshake between a command source (master) and stack_sequencer (slave).
interface stack_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_imm;

  modport master (output cmd_valid, output cmd_op, output cmd_imm, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_imm, output cmd_ready);
endinterface

// File: rtl/stack_sequencer.sv
// Command sequencer for register_stack: depth tracking, overflow/underflow checks, POPN expansion.
// Optional AND/OR binary ops are built only when STACK_SEQ_LOGIC_EN is defined.
//   state | meaning
//   IDLE  | ready for a command, register_stack held with nop
//   EXEC  | issuing stackOP/w for the latched command (several cycles for POPN)
module stack_sequencer #(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  stack_sequencer_if.slave   cmd,
  input  logic [15:0]        a,
  input  logic [15:0]        b,
  output logic [2:0]         stackOP,
  output logic [15:0]        w,
  output logic [DEPTH_W-1:0] depth,
  output logic               busy,
  output logic               err,
  output logic [1:0]         err_code
);
  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_PUSH   = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_POP    = 4'd6;
  localparam logic [3:0] OP_SWAP   = 4'd7;
  localparam logic [3:0] OP_DUP    = 4'd8;
  localparam logic [3:0] OP_OVER   = 4'd9;
  localparam logic [3:0] OP_POPN   = 4'd10;
  localparam logic [3:0] OP_ERRCLR = 4'd11;

  localparam logic [2:0] SOP_NOP  = 3'd0;
  localparam logic [2:0] SOP_PUSH = 3'd1;
  localparam logic [2:0] SOP_REPL = 3'd2;
  localparam logic [2:0] SOP_POP  = 3'd3;
  localparam logic [2:0] SOP_POP2 = 3'd4;
  localparam logic [2:0] SOP_SWAP = 3'd5;

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_OVF  = 2'd1;
  localparam logic [1:0] E_UNF  = 2'd2;
  localparam logic [1:0] E_ILL  = 2'd3;

  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] ZERO = '0;
  localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] TWO  = DEPTH_W'(2);

  state_t             state, state_n;
  logic [3:0]         op_q;
  logic [15:0]        imm_q;
  logic [DEPTH_W-1:0] rem, rem_n, depth_n;
  logic               first;
  logic [2:0]         sop_n;
  logic [15:0]        w_n;
  logic [1:0]         code;
  logic               last;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    sop_n   = SOP_NOP;
    w_n     = '0;
    code    = E_NONE;
    depth_n = depth;
    rem_n   = rem;
    last    = 1'b1;
    case (op_q)
      OP_NOP, OP_ERRCLR: ;
      OP_PUSH:
        if (depth == FULL) code = E_OVF;
        else begin
          sop_n   = SOP_PUSH;
          w_n     = imm_q;
          depth_n = depth + ONE;
        end
      OP_ADD, OP_SUB:
        if (depth < TWO) code = E_UNF;
        else begin
          sop_n   = SOP_REPL;
          w_n     = (op_q == OP_ADD) ? b + a : b - a;
          depth_n = depth - ONE;
        end
`ifdef STACK_SEQ_LOGIC_EN
      OP_AND, OP_OR:
        if (depth < TWO) code = E_UNF;
        else begin
          sop_n   = SOP_REPL;
          w_n     = (op_q == OP_AND) ? (b & a) : (b | a);
          depth_n = depth - ONE;
        end
`endif
      OP_POP:
        if (depth == ZERO) code = E_UNF;
        else begin
          sop_n   = SOP_POP;
          depth_n = depth - ONE;
        end
      OP_SWAP:
        if (depth < TWO) code = E_UNF;
        else sop_n = SOP_SWAP;
      OP_DUP:
        if (depth == ZERO) code = E_UNF;
        else if (depth == FULL) code = E_OVF;
        else begin
          sop_n   = SOP_PUSH;
          w_n     = a;
          depth_n = depth + ONE;
        end
      OP_OVER:
        if (depth < TWO) code = E_UNF;
        else if (depth == FULL) code = E_OVF;
        else begin
          sop_n   = SOP_PUSH;
          w_n     = b;
          depth_n = depth + ONE;
        end
      OP_POPN: begin
        // Only the entry cycle checks; later cycles are covered by that check.
        if (first && depth < rem) code = E_UNF;
        else if (rem >= TWO) begin
          sop_n   = SOP_POP2;
          depth_n = depth - TWO;
          rem_n   = rem - TWO;
          last    = (rem == TWO);
        end else if (rem == ONE) begin
          sop_n   = SOP_POP;
          depth_n = depth - ONE;
          rem_n   = ZERO;
        end
      end
      default: code = E_ILL;
    endcase

    state_n = state;
    case (state)
      IDLE:    if (cmd.cmd_valid) state_n = EXEC;
      EXEC:    if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state == EXEC);
  assign stackOP       = (RST_N && state == EXEC) ? sop_n : SOP_NOP;
  assign w             = (RST_N && state == EXEC) ? w_n : 16'h0000;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      op_q     <= OP_NOP;
      imm_q    <= '0;
      rem      <= '0;
      first    <= 1'b0;
      depth    <= '0;
      err      <= 1'b0;
      err_code <= E_NONE;
    end else if (state == IDLE) begin
      if (cmd.cmd_valid) begin
        op_q  <= cmd.cmd_op;
        imm_q <= cmd.cmd_imm;
        rem   <= cmd.cmd_imm[DEPTH_W-1:0];
        first <= 1'b1;
      end
    end else begin
      depth <= depth_n;
      rem   <= rem_n;
      first <= 1'b0;
      if (op_q == OP_ERRCLR) begin
        err      <= 1'b0;
        err_code <= E_NONE;
      end else if (code != E_NONE) begin
        err <= 1'b1;
        if (!err) err_code <= code;
      end
    end
  end
endmodule
